// File: rtl/elevator_pkg.sv
// Shared types and constants for the SCAN elevator controller.
// Holds the FSM state enum, direction encoding and climate defaults.
package elevator_pkg;

  typedef enum logic [2:0] {
    OFF,
    IDLE,
    DECIDE,
    MOVE,
    DOOR
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int TEMP_LO_DEF = 24;
  localparam int TEMP_HI_DEF = 26;

endpackage

// File: rtl/elevator_scan_ctrl_if.sv
// Front-end / driver bundle of one elevator car.
// ELEV_DOOR_HOLD_EN adds the door_hold input.
interface elevator_scan_ctrl_if #(
  parameter int NUM_FLOORS = 10,
  parameter int TEMP_W     = 8
);
  localparam int FLOOR_W = $clog2(NUM_FLOORS);

  logic                  off_btn;
  logic [NUM_FLOORS-1:0] hall_up_req;
  logic [NUM_FLOORS-1:0] hall_dn_req;
  logic [NUM_FLOORS-1:0] car_req;
  logic [TEMP_W-1:0]     temp;
`ifdef ELEV_DOOR_HOLD_EN
  logic                  door_hold;
`endif
  logic [FLOOR_W-1:0]    floor;
  logic                  direction;
  logic                  moving;
  logic                  door;
  logic                  cooler;
  logic                  heater;
  logic                  served;
  logic [NUM_FLOORS-1:0] pending;

  modport master (
    output off_btn, hall_up_req, hall_dn_req,
    output car_req, temp,
`ifdef ELEV_DOOR_HOLD_EN
    output door_hold,
`endif
    input  floor, direction, moving, door,
    input  cooler, heater, served, pending
  );

  modport slave (
    input  off_btn, hall_up_req, hall_dn_req,
    input  car_req, temp,
`ifdef ELEV_DOOR_HOLD_EN
    input  door_hold,
`endif
    output floor, direction, moving, door,
    output cooler, heater, served, pending
  );

endinterface

// File: rtl/elevator_req_scan.sv
// Summarises pending requests relative to a floor:
// counts, nearest floors and ahead/behind flags.
module elevator_req_scan
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 10,
  parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input  logic [FLOOR_W-1:0]    floor,
  input  logic                  direction,
  input  logic [NUM_FLOORS-1:0] pending,
  output logic [FLOOR_W-1:0]    cnt_above,
  output logic [FLOOR_W-1:0]    cnt_below,
  output logic [FLOOR_W-1:0]    nearest_above,
  output logic [FLOOR_W-1:0]    nearest_below,
  output logic                  any_ahead,
  output logic                  any_behind
);

  logic has_above;
  logic has_below;

  // count floors with requests on each side; keep the closest one
  always_comb begin
    cnt_above     = '0;
    cnt_below     = '0;
    nearest_above = floor;
    nearest_below = floor;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && FLOOR_W'(i) > floor) begin
        cnt_above     = cnt_above + FLOOR_W'(1);
        nearest_above = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && FLOOR_W'(i) < floor) begin
        cnt_below     = cnt_below + FLOOR_W'(1);
        nearest_below = FLOOR_W'(i);
      end
    end
  end

  assign has_above  = cnt_above != '0;
  assign has_below  = cnt_below != '0;
  assign any_ahead  = (direction == DIR_UP) ?
                      has_above : has_below;
  assign any_behind = (direction == DIR_UP) ?
                      has_below : has_above;

endmodule

// File: rtl/elevator_scan_ctrl.sv
// N-floor SCAN car controller: requests, travel, door, climate.
// ELEV_DOOR_HOLD_EN enables the door_hold input.
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS  = 10,
  parameter int TEMP_W      = 8,
  parameter int TEMP_LO     = TEMP_LO_DEF,
  parameter int TEMP_HI     = TEMP_HI_DEF,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 8
) (
  input logic clock,
  input logic reset,
  elevator_scan_ctrl_if.slave bus
);

  localparam int FLOOR_W = $clog2(NUM_FLOORS);
  localparam int TMAX = (MOVE_CYCLES > DOOR_CYCLES) ?
                        MOVE_CYCLES : DOOR_CYCLES;
  localparam int TMR_W = $clog2(TMAX + 1);

  localparam logic [FLOOR_W-1:0] TOP =
    FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [TMR_W-1:0] MOVE_LD =
    TMR_W'(MOVE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DOOR_LD =
    TMR_W'(DOOR_CYCLES - 1);
  localparam logic [NUM_FLOORS-1:0] UP_MASK =
    ~(NUM_FLOORS'(1) << (NUM_FLOORS - 1));
  localparam logic [NUM_FLOORS-1:0] DN_MASK =
    ~NUM_FLOORS'(1);
  localparam logic [TEMP_W-1:0] T_LO  = TEMP_W'(TEMP_LO);
  localparam logic [TEMP_W-1:0] T_HI  = TEMP_W'(TEMP_HI);
  localparam logic [TEMP_W-1:0] T_LO1 = TEMP_W'(TEMP_LO + 1);
  localparam logic [TEMP_W-1:0] T_HI1 = TEMP_W'(TEMP_HI - 1);

  state_t               state;
  logic [FLOOR_W-1:0]   floor_q;
  logic                 dir_q;
  logic [TMR_W-1:0]     timer;
  logic                 moving_q;
  logic                 door_q;
  logic                 served_q;
  logic                 cooler_q;
  logic                 heater_q;
  logic [NUM_FLOORS-1:0] req_up;
  logic [NUM_FLOORS-1:0] req_dn;
  logic [NUM_FLOORS-1:0] req_car;
  logic [NUM_FLOORS-1:0] pend;

  logic [FLOOR_W-1:0]   h_cnt_above;
  logic [FLOOR_W-1:0]   h_cnt_below;
  logic [FLOOR_W-1:0]   h_near_above;
  logic [FLOOR_W-1:0]   h_near_below;
  logic                 h_ahead;
  logic                 h_behind;

  logic [FLOOR_W-1:0]   arr_floor;
  logic                 arr_dir;
  logic                 n_ahead;
  logic                 hold;
  logic                 here_req;
  logic                 mv_done;
  logic                 stop_now;
  logic                 door_done;
  logic                 enter_door;
  logic                 pick_up;
  logic [FLOOR_W-1:0]   clr_floor;
  logic                 clr_dir;
  logic                 clr_ahead;
  logic [NUM_FLOORS-1:0] clr_bit;
  logic [NUM_FLOORS-1:0] clr_up;
  logic [NUM_FLOORS-1:0] clr_dn;

  assign pend     = req_up | req_dn | req_car;
  assign here_req = pend[floor_q];

  elevator_req_scan #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_here (
    .floor         (floor_q),
    .direction     (dir_q),
    .pending       (pend),
    .cnt_above     (h_cnt_above),
    .cnt_below     (h_cnt_below),
    .nearest_above (h_near_above),
    .nearest_below (h_near_below),
    .any_ahead     (h_ahead),
    .any_behind    (h_behind)
  );

`ifdef ELEV_DOOR_HOLD_EN
  assign hold = bus.door_hold;
`else
  assign hold = 1'b0;
`endif

  assign arr_floor =
    (dir_q == DIR_UP && floor_q != TOP) ?
      floor_q + FLOOR_W'(1) :
    (dir_q == DIR_DOWN && floor_q != '0) ?
      floor_q - FLOOR_W'(1) : floor_q;
  assign arr_dir =
    (arr_floor == TOP) ? DIR_DOWN :
    (arr_floor == '0)  ? DIR_UP   : dir_q;

  // any request beyond the floor being arrived at
  always_comb begin
    n_ahead = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pend[i] &&
          ((arr_dir == DIR_UP) ?
            FLOOR_W'(i) > arr_floor :
            FLOOR_W'(i) < arr_floor))
        n_ahead = 1'b1;
    end
  end

  assign mv_done  = state == MOVE && timer == '0;
  assign stop_now = mv_done &&
    (req_car[arr_floor] || !n_ahead ||
     ((arr_dir == DIR_UP) ?
       req_up[arr_floor] : req_dn[arr_floor]));
  assign door_done = state == DOOR &&
                     timer == '0 && !hold;
  assign enter_door = !bus.off_btn &&
    ((state == IDLE && here_req) || stop_now ||
     (door_done && !h_ahead && !h_behind && here_req));

  assign clr_floor = stop_now ? arr_floor : floor_q;
  assign clr_dir   = stop_now ? arr_dir   : dir_q;
  assign clr_ahead = stop_now ? n_ahead   : h_ahead;
  assign clr_bit   = enter_door ?
                     (NUM_FLOORS'(1) << clr_floor) : '0;
  assign clr_up = (clr_dir == DIR_UP || !clr_ahead) ?
                  clr_bit : '0;
  assign clr_dn = (clr_dir == DIR_DOWN || !clr_ahead) ?
                  clr_bit : '0;

  assign pick_up =
    (h_cnt_above > h_cnt_below) ? 1'b1 :
    (h_cnt_above < h_cnt_below) ? 1'b0 :
    ((h_near_above - floor_q) <
     (floor_q - h_near_below));

  // latch requests; serving a floor beats a same-cycle pulse
  always_ff @(posedge clock) begin
    if (!reset || bus.off_btn || state == OFF) begin
      req_up  <= '0;
      req_dn  <= '0;
      req_car <= '0;
    end else begin
      req_up  <= (req_up | (bus.hall_up_req & UP_MASK))
                 & ~clr_up;
      req_dn  <= (req_dn | (bus.hall_dn_req & DN_MASK))
                 & ~clr_dn;
      req_car <= (req_car | bus.car_req) & ~clr_bit;
    end
  end

  // car FSM: position, direction, timers, status outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      floor_q  <= '0;
      dir_q    <= DIR_DOWN;
      timer    <= '0;
      moving_q <= 1'b0;
      door_q   <= 1'b0;
      served_q <= 1'b0;
    end else if (bus.off_btn) begin
      state    <= OFF;
      timer    <= '0;
      moving_q <= 1'b0;
      door_q   <= 1'b0;
      served_q <= 1'b0;
    end else begin
      served_q <= enter_door;
      case (state)
        OFF: state <= IDLE;
        IDLE: begin
          if (here_req) begin
            state  <= DOOR;
            door_q <= 1'b1;
            timer  <= DOOR_LD;
          end else if (|pend) begin
            state <= DECIDE;
          end
        end
        DECIDE: begin
          dir_q    <= pick_up ? DIR_UP : DIR_DOWN;
          state    <= MOVE;
          moving_q <= 1'b1;
          timer    <= MOVE_LD;
        end
        MOVE: begin
          if (timer != '0) begin
            timer <= timer - TMR_W'(1);
          end else begin
            floor_q <= arr_floor;
            dir_q   <= arr_dir;
            if (stop_now) begin
              state    <= DOOR;
              moving_q <= 1'b0;
              door_q   <= 1'b1;
              timer    <= DOOR_LD;
            end else begin
              timer <= MOVE_LD;
            end
          end
        end
        DOOR: begin
          if (hold) begin
            timer <= DOOR_LD;
          end else if (timer != '0) begin
            timer <= timer - TMR_W'(1);
          end else if (h_ahead) begin
            state    <= MOVE;
            door_q   <= 1'b0;
            moving_q <= 1'b1;
            timer    <= MOVE_LD;
          end else if (h_behind) begin
            dir_q    <= ~dir_q;
            state    <= MOVE;
            door_q   <= 1'b0;
            moving_q <= 1'b1;
            timer    <= MOVE_LD;
          end else if (here_req) begin
            timer <= DOOR_LD;
          end else begin
            state  <= IDLE;
            door_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // climate with a dead band; forced off while the car is off
  always_ff @(posedge clock) begin
    if (!reset || bus.off_btn || state == OFF) begin
      cooler_q <= 1'b0;
      heater_q <= 1'b0;
    end else if (bus.temp > T_HI) begin
      cooler_q <= 1'b1;
      heater_q <= 1'b0;
    end else if (bus.temp < T_LO) begin
      cooler_q <= 1'b0;
      heater_q <= 1'b1;
    end else if (bus.temp >= T_LO1 &&
                 bus.temp <= T_HI1) begin
      cooler_q <= 1'b0;
      heater_q <= 1'b0;
    end
  end

  assign bus.floor     = floor_q;
  assign bus.direction = dir_q;
  assign bus.moving    = moving_q;
  assign bus.door      = door_q;
  assign bus.served    = served_q;
  assign bus.cooler    = cooler_q;
  assign bus.heater    = heater_q;
  assign bus.pending   = pend;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl.
// Climate table plus hand-timed travel/door/off sequences.
module tb_elevator_scan_ctrl;

  localparam int NF = 10;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  elevator_scan_ctrl_if #(
    .NUM_FLOORS (NF),
    .TEMP_W     (8)
  ) bus ();

  elevator_scan_ctrl #(
    .NUM_FLOORS  (NF),
    .TEMP_W      (8),
    .TEMP_LO     (24),
    .TEMP_HI     (26),
    .MOVE_CYCLES (4),
    .DOOR_CYCLES (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] temp;
    logic       cooler;
    logic       heater;
  } clim_vec_t;

  clim_vec_t tbl [9];

  function automatic logic [NF-1:0] fb(input int f);
    return NF'(1) << f;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse(input logic [NF-1:0] up,
                       input logic [NF-1:0] dn,
                       input logic [NF-1:0] car);
    bus.hall_up_req = up;
    bus.hall_dn_req = dn;
    bus.car_req     = car;
    @(negedge clock);
    bus.hall_up_req = '0;
    bus.hall_dn_req = '0;
    bus.car_req     = '0;
  endtask

  task automatic wait_door(input string nm);
    int n;
    n = 0;
    while (bus.door === 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    while (bus.door !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk({nm, "_door_timeout"}, bus.door, 1);
  endtask

  task automatic wait_closed(input string nm);
    int n;
    n = 0;
    while (bus.door === 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk({nm, "_close_timeout"}, bus.door, 0);
  endtask

  task automatic goto(input int f);
    pulse('0, '0, fb(f));
    wait_door("goto");
    chk($sformatf("goto_floor%0d", f), bus.floor, f);
    wait_closed("goto");
  endtask

  initial begin
    tbl[0] = '{8'd30, 1'b1, 1'b0};
    tbl[1] = '{8'd26, 1'b1, 1'b0};
    tbl[2] = '{8'd25, 1'b0, 1'b0};
    tbl[3] = '{8'd24, 1'b0, 1'b0};
    tbl[4] = '{8'd20, 1'b0, 1'b1};
    tbl[5] = '{8'd24, 1'b0, 1'b1};
    tbl[6] = '{8'd25, 1'b0, 1'b0};
    tbl[7] = '{8'd27, 1'b1, 1'b0};
    tbl[8] = '{8'd23, 1'b0, 1'b1};

    reset           = 1'b0;
    bus.off_btn     = 1'b0;
    bus.hall_up_req = '0;
    bus.hall_dn_req = '0;
    bus.car_req     = '0;
    bus.temp        = 8'd25;
`ifdef ELEV_DOOR_HOLD_EN
    bus.door_hold   = 1'b0;
`endif
    cyc(2);
    chk("rst_floor",   bus.floor,     0);
    chk("rst_dir",     bus.direction, 0);
    chk("rst_moving",  bus.moving,    0);
    chk("rst_door",    bus.door,      0);
    chk("rst_served",  bus.served,    0);
    chk("rst_pending", bus.pending,   0);
    chk("rst_cooler",  bus.cooler,    0);
    chk("rst_heater",  bus.heater,    0);
    reset = 1'b1;
    cyc(1);

    // climate hysteresis table
    for (int i = 0; i < 9; i++) begin
      bus.temp = tbl[i].temp;
      cyc(1);
      chk($sformatf("clim_cool%0d", i),
          bus.cooler, tbl[i].cooler);
      chk($sformatf("clim_heat%0d", i),
          bus.heater, tbl[i].heater);
    end

    // floor 0 -> car request at 3, exact timing
    pulse('0, '0, fb(3));
    chk("t1_pend", bus.pending, fb(3));
    cyc(1);
    chk("t1_decide_mv", bus.moving, 0);
    cyc(1);
    chk("t1_dir", bus.direction, 1);
    chk("t1_mv", bus.moving, 1);
    cyc(11);
    chk("t1_f2", bus.floor, 2);
    chk("t1_door0", bus.door, 0);
    cyc(1);
    chk("t1_f3", bus.floor, 3);
    chk("t1_door1", bus.door, 1);
    chk("t1_served", bus.served, 1);
    chk("t1_mv_off", bus.moving, 0);
    chk("t1_clr", bus.pending, 0);
    cyc(1);
    chk("t1_served_pulse", bus.served, 0);
    cyc(6);
    chk("t1_door_last", bus.door, 1);
    cyc(1);
    chk("t1_door_shut", bus.door, 0);
    chk("t1_idle_mv", bus.moving, 0);

    // request at the current floor: door two edges later
    pulse('0, '0, fb(3));
    chk("lat_door0", bus.door, 0);
    cyc(1);
    chk("lat_door1", bus.door, 1);
    chk("lat_served", bus.served, 1);
    wait_closed("lat");

    // tie on count and distance goes down
    goto(4);
    pulse('0, '0, fb(6) | fb(2));
    cyc(2);
    chk("t3_dir", bus.direction, 0);
    chk("t3_mv", bus.moving, 1);
    wait_door("t3a");
    chk("t3_stop2", bus.floor, 2);
    wait_door("t3b");
    chk("t3_stop6", bus.floor, 6);
    chk("t3_dir6", bus.direction, 1);
    wait_closed("t3");

    // more below than above: 2, then 1, then up to 7
    goto(5);
    pulse(fb(7), fb(1), fb(2));
    cyc(2);
    chk("t2_dir", bus.direction, 0);
    wait_door("t2a");
    chk("t2_stop2", bus.floor, 2);
    chk("t2_pend2", bus.pending, fb(1) | fb(7));
    wait_door("t2b");
    chk("t2_stop1", bus.floor, 1);
    chk("t2_dir1", bus.direction, 0);
    chk("t2_pend1", bus.pending, fb(7));
    wait_door("t2c");
    chk("t2_stop7", bus.floor, 7);
    chk("t2_dir7", bus.direction, 1);
    chk("t2_pend7", bus.pending, 0);
    wait_closed("t2");

    // top floor: up hall ignored, down hall opens door
    goto(9);
    chk("t4_dir_top", bus.direction, 0);
    pulse(fb(9), '0, '0);
    cyc(2);
    chk("t4_up_ign", bus.pending, 0);
    chk("t4_up_door", bus.door, 0);
    chk("t4_up_mv", bus.moving, 0);
    pulse('0, fb(9), '0);
    cyc(1);
    chk("t4_dn_door", bus.door, 1);
    chk("t4_dn_floor", bus.floor, 9);
    chk("t4_dn_mv", bus.moving, 0);
    chk("t4_dn_clr", bus.pending, 0);
    wait_closed("t4");

    // off mid-move at floor 2
    goto(2);
    bus.temp = 8'd30;
    pulse('0, '0, fb(5) | fb(7));
    cyc(2);
    chk("t5_mv", bus.moving, 1);
    chk("t5_floor", bus.floor, 2);
    chk("t5_pend", bus.pending, fb(5) | fb(7));
    chk("t5_cool", bus.cooler, 1);
    bus.off_btn = 1'b1;
    cyc(1);
    chk("t5_off_mv", bus.moving, 0);
    chk("t5_off_door", bus.door, 0);
    chk("t5_off_pend", bus.pending, 0);
    chk("t5_off_floor", bus.floor, 2);
    chk("t5_off_cool", bus.cooler, 0);
    chk("t5_off_heat", bus.heater, 0);
    pulse('0, '0, fb(8));
    cyc(1);
    chk("t5_off_ign", bus.pending, 0);
    bus.off_btn = 1'b0;
    cyc(3);
    chk("t5_on_pend", bus.pending, 0);
    chk("t5_on_mv", bus.moving, 0);
    chk("t5_on_door", bus.door, 0);
    chk("t5_on_floor", bus.floor, 2);
    chk("t5_on_cool", bus.cooler, 1);

`ifdef ELEV_DOOR_HOLD_EN
    // door held open, then closes DOOR_CYCLES later
    pulse('0, '0, fb(2));
    cyc(1);
    chk("hold_open0", bus.door, 1);
    bus.door_hold = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      chk($sformatf("hold_open%0d", k + 1), bus.door, 1);
    end
    bus.door_hold = 1'b0;
    cyc(7);
    chk("hold_last", bus.door, 1);
    cyc(1);
    chk("hold_shut", bus.door, 0);
`endif

    // reset beats off_btn: car accepts requests right after
    reset = 1'b0;
    bus.off_btn = 1'b1;
    cyc(1);
    reset = 1'b1;
    bus.off_btn = 1'b0;
    pulse('0, '0, fb(1));
    chk("rp_pend", bus.pending, fb(1));
    chk("rp_floor", bus.floor, 0);
    chk("rp_dir", bus.direction, 0);
    chk("rp_cool", bus.cooler, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
